// File: rtl/mvu_pe_popcount_acc_if.sv
// mvu_pe_popcount_acc_if: input beat stream and output result stream of the popcount accumulator
interface mvu_pe_popcount_acc_if #(parameter int SIMD = 8, parameter int TO = 16);
  logic            in_v;
  logic            in_rdy;
  logic [SIMD-1:0] in_xnor;
  logic            out_v;
  logic            out_rdy;
  logic [TO-1:0]   out;
  modport master (output in_v, in_xnor, out_rdy, input in_rdy, out_v, out);
  modport slave (input in_v, in_xnor, out_rdy, output in_rdy, out_v, out);
endinterface

// File: rtl/mvu_pe_popcount_acc.sv
// mvu_pe_popcount_acc: popcounts SIMD XNOR bits per beat and accumulates SF beats into one dot-product word
module mvu_pe_popcount_acc #(
  parameter int SIMD    = 8,
  parameter int SF      = 4,
  parameter int TO      = 16,
  parameter int BIPOLAR = 0
) (
  input  logic clk,
  input  logic rst,
  mvu_pe_popcount_acc_if.slave bus
);
  localparam int AW = $clog2(SIMD*SF+1);
  localparam int PW = $clog2(SIMD+1);
  localparam int CW = SF > 1 ? $clog2(SF) : 1;
  if (TO < AW + 1) begin : g_to_check
    $error("TO too narrow for SIMD*SF");
  end
  logic [PW-1:0] pc;
  logic [AW-1:0] acc_q, acc_d, sum;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TO-1:0] res_q, res_d, ext;
  logic          pend_q, pend_d, last, fire, take;
  always_comb begin
    pc = '0;
    for (int i = 0; i < SIMD; i++) pc = pc + PW'(bus.in_xnor[i]);
  end
  assign last       = cnt_q == CW'(SF-1);
  assign bus.in_rdy = !(pend_q && !bus.out_rdy && last);
  assign bus.out_v  = pend_q;
  assign bus.out    = res_q;
  assign fire       = bus.in_v && bus.in_rdy;
  assign take       = pend_q && bus.out_rdy;
  // beat 0 starts a fresh sum so no clear cycle is needed between vectors
  assign sum = (cnt_q == '0 ? '0 : acc_q) + AW'(pc);
  assign ext = TO'(sum);
  always_comb begin
    acc_d  = fire ? sum : acc_q;
    cnt_d  = fire ? (last ? '0 : cnt_q + CW'(1)) : cnt_q;
    res_d  = fire && last ? (BIPOLAR != 0 ? (ext << 1) - TO'(SIMD*SF) : ext) : res_q;
    pend_d = (fire && last) || (pend_q && !take);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      res_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      res_q  <= res_d;
      pend_q <= pend_d;
    end
  end
endmodule

// File: tb/tb_mvu_pe_popcount_acc.sv
// tb_mvu_pe_popcount_acc: directed plan plus random traffic against a behavioural model, SF=4 unipolar and SF=1 bipolar
module tb_mvu_pe_popcount_acc;
  logic clk = 1'b0, rst = 1'b1, in_v = 1'b0, out_rdy = 1'b1, started = 1'b0;
  logic [7:0] in_xnor = '0;
  int n_chk = 0, n_fail = 0;
  int sfv [2] = '{4, 1};
  int bip [2] = '{0, 1};
  int m_n [2], m_sum [2];
  bit m_pend [2];
  logic [15:0] m_res [2];
  logic rdy [2], ov [2];
  logic [15:0] od [2];
  logic [15:0] got0 [$], got1 [$];

  always #5 clk = ~clk;

  mvu_pe_popcount_acc_if #(.SIMD(8), .TO(16)) b0 ();
  mvu_pe_popcount_acc_if #(.SIMD(8), .TO(16)) b1 ();
  assign b0.in_v = in_v;  assign b0.in_xnor = in_xnor;  assign b0.out_rdy = out_rdy;
  assign b1.in_v = in_v;  assign b1.in_xnor = in_xnor;  assign b1.out_rdy = out_rdy;
  assign rdy[0] = b0.in_rdy;  assign ov[0] = b0.out_v;  assign od[0] = b0.out;
  assign rdy[1] = b1.in_rdy;  assign ov[1] = b1.out_v;  assign od[1] = b1.out;

  mvu_pe_popcount_acc #(.SIMD(8), .SF(4), .TO(16), .BIPOLAR(0)) dut0 (.clk(clk), .rst(rst), .bus(b0.slave));
  mvu_pe_popcount_acc #(.SIMD(8), .SF(1), .TO(16), .BIPOLAR(1)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit exp_rdy(input int k);
    return !(m_pend[k] && !out_rdy && m_n[k] == sfv[k] - 1);
  endfunction

  // Reference: a vector is SF accepted beats; its result is the summed popcount, optionally mapped to +/-1 form
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_n[k] = 0; m_sum[k] = 0; m_pend[k] = 0; m_res[k] = '0;
      end else begin
        bit fire;
        fire = in_v && exp_rdy(k);
        if (m_pend[k] && out_rdy) m_pend[k] = 0;
        if (fire) begin
          m_sum[k] = (m_n[k] == 0 ? 0 : m_sum[k]) + $countones(in_xnor);
          if (m_n[k] == sfv[k] - 1) begin
            m_res[k]  = bip[k] != 0 ? 16'(2*m_sum[k] - 8*sfv[k]) : 16'(m_sum[k]);
            m_pend[k] = 1;
            m_n[k]    = 0;
          end else m_n[k]++;
        end
      end
    end
    if (rst) started <= 1'b1;
  end

  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("in_rdy[%0d]", k), 32'(rdy[k]), 32'(exp_rdy(k)));
        chk($sformatf("out_v[%0d]", k), 32'(ov[k]), 32'(m_pend[k]));
        chk($sformatf("out[%0d]", k), 32'(od[k]), 32'(m_res[k]));
      end
      if (!rst && ov[0] && out_rdy) got0.push_back(od[0]);
      if (!rst && ov[1] && out_rdy) got1.push_back(od[1]);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic beat(input logic [7:0] x);
    in_v = 1'b1; in_xnor = x; tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      in_v = 1'b0; in_xnor = 8'($urandom); tick();
    end
  endtask

  task automatic q0(input string name, input int idx, input logic [15:0] exp);
    if (got0.size() <= idx) chk({name, "_missing"}, 32'(got0.size()), 32'(idx + 1));
    else chk(name, 32'(got0[idx]), 32'(exp));
  endtask

  task automatic q1(input string name, input int idx, input logic [15:0] exp);
    if (got1.size() <= idx) chk({name, "_missing"}, 32'(got1.size()), 32'(idx + 1));
    else chk(name, 32'(got1[idx]), 32'(exp));
  endtask

  initial begin
    tick(); tick();
    rst = 1'b0;
    chk("rst_out_v", 32'(b0.out_v), 0);
    chk("rst_out", 32'(b0.out), 0);
    chk("rst_in_rdy", 32'(b0.in_rdy), 1);
    got0.delete();
    repeat (4) beat(8'hFF);
    chk("t1_latency_v", 32'(b0.out_v), 1);
    chk("t1_latency_out", 32'(b0.out), 32);
    idle(2);
    q0("t1_res", 0, 16'd32);
    got0.delete();
    repeat (4) beat(8'hAA);
    repeat (4) beat(8'h00);
    idle(2);
    q0("t2_first", 0, 16'd16);
    q0("t2_second", 1, 16'd0);
    got0.delete();
    repeat (4) beat(8'hFF);
    out_rdy = 1'b0;
    repeat (3) beat(8'h0F);
    in_v = 1'b1; in_xnor = 8'h0F; #1;
    chk("t3_stall_rdy", 32'(b0.in_rdy), 0);
    chk("t3_hold_out", 32'(b0.out), 32);
    tick(); tick();
    chk("t3_hold_out2", 32'(b0.out), 32);
    chk("t3_hold_v", 32'(b0.out_v), 1);
    out_rdy = 1'b1; #1;
    chk("t3_release_rdy", 32'(b0.in_rdy), 1);
    tick();
    in_v = 1'b0;
    chk("t3_next_v", 32'(b0.out_v), 1);
    chk("t3_next_out", 32'(b0.out), 16);
    idle(2);
    q0("t3_first", 0, 16'd32);
    q0("t3_second", 1, 16'd16);
    got0.delete();
    repeat (2) beat(8'hFF);
    in_v = 1'b0; rst = 1'b1; tick();
    chk("t4_rst_v", 32'(b0.out_v), 0);
    chk("t4_rst_out", 32'(b0.out), 0);
    rst = 1'b0; #1;
    chk("t4_post_rdy", 32'(b0.in_rdy), 1);
    repeat (4) beat(8'h01);
    idle(2);
    q0("t4_res", 0, 16'd4);
    got0.delete();
    repeat (4) begin beat(8'h03); idle(1); end
    idle(1);
    q0("t5_res", 0, 16'd8);
    got1.delete();
    beat(8'h01);
    chk("t6_a", 32'(b1.out), 32'h0000FFFA);
    beat(8'h03);
    chk("t6_b", 32'(b1.out), 32'h0000FFFC);
    beat(8'h07);
    chk("t6_c", 32'(b1.out), 32'h0000FFFE);
    idle(1);
    q1("t6_q0", 0, 16'hFFFA);
    q1("t6_q1", 1, 16'hFFFC);
    q1("t6_q2", 2, 16'hFFFE);
    for (int i = 0; i < 3000; i++) begin
      in_v    = $urandom_range(0, 3) != 0;
      in_xnor = 8'($urandom);
      out_rdy = $urandom_range(0, 9) < 6;
      rst     = $urandom_range(0, 299) == 0;
      tick();
    end
    rst = 1'b0; in_v = 1'b0; out_rdy = 1'b1;
    idle(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mvu_pe_popcount_acc.md
Name: mvu_pe_popcount_acc

Overview:
- Consumer end of the XNOR SIMD lanes in a binarised MVU processing element.
- Takes SIMD XNOR result bits per beat and popcounts them.
- Accumulates across SF folded beats and emits one dot-product word per output neuron, with valid/ready handshakes on both sides.
- Sits between the XNOR SIMD array and the PE output / threshold stage.

Parameters:
- SIMD, 8: XNOR lanes per beat (input bit width).
- SF, 4: beats per dot product (synapse fold); SF >= 1.
- TO, 16: output word width. Must be >= $clog2(SIMD*SF+1)+1 (checked by elaboration assertion).
- BIPOLAR, 0: 0 = output raw popcount (unsigned); 1 = output 2*popcount - SIMD*SF (two's complement, i.e. the +/-1 dot product).

Ports:
- clk, input, 1: clock, all logic on posedge.
- rst, input, 1: synchronous reset, active-high.
- in_v, input, 1: input beat valid.
- in_rdy, output, 1: block can accept a beat.
- in_xnor, input, SIMD: XNOR bits from SIMD lanes.
- out_v, output, 1: result valid.
- out_rdy, input, 1: downstream accepts result.
- out, output, TO: accumulated dot product.

Behaviour:
- Beat accepted when in_v && in_rdy. Result taken when out_v && out_rdy.
- Combinational popcount of in_xnor, width $clog2(SIMD+1), feeds the adder directly. No extra pipeline stage.
- Internal state:
  - acc: width $clog2(SIMD*SF+1).
  - beat counter cnt: 0..SF-1.
  - result register res (TO bits) plus pending flag; out_v = pending.
- Non-last accepted beat (cnt < SF-1):
  - acc <= acc + pc. If cnt == 0, acc <= pc (fresh start, no separate clear cycle).
  - cnt <= cnt+1.
- Last accepted beat (cnt == SF-1):
  - res <= f(acc_or_0 + pc), where f is the identity or the bipolar map, sign-extended/zero-extended to TO.
  - pending <= 1; cnt <= 0.
- SF == 1: every accepted beat is last, and res = f(pc).
- Latency: out_v rises the cycle after the last beat is accepted. Throughput is one beat per cycle, sustained when out_rdy is held high.
- in_rdy = !(pending && !out_rdy && cnt == SF-1). Non-last beats keep accumulating while a result waits. Only the last beat stalls.
- Simultaneous result taken and new last beat accepted in the same cycle: res reloads and pending stays 1 (no bubble).
- Result taken with no new last beat: pending <= 0.
- out holds its value while out_v && !out_rdy. The out value is don't-care (held) when out_v = 0.
- in_xnor is ignored when in_v = 0; state is unchanged.
- Reset (any cycle, including mid-accumulation or mid-stall):
  - acc=0, cnt=0, pending=0, out_v=0, out=0.
  - in_rdy=1 from the first cycle after reset.
  - Partial accumulation is discarded; the next accepted beat is beat 0.
- No overflow is possible given the TO constraint. Bipolar range is [-SIMD*SF, +SIMD*SF].

Test Plan (SIMD=8, SF=4 unless noted):
1. Reset, then 4 beats of in_xnor=8'hFF with out_rdy=1 -> out_v pulses one cycle after beat 4, out=32 (BIPOLAR=1: out=32). in_rdy stays 1.
2. 4 beats of 8'hAA, then 4 beats of 8'h00, back-to-back with out_rdy=1 -> out=16 then out=0. BIPOLAR=1: out=0 then out=-32 (16'hFFE0). No idle cycles between the two vectors.
3. Backpressure: out_rdy=0 after first result (32), then stream a second vector 8'h0F x4 -> beats 1-3 accepted, in_rdy=0 at beat 4, out holds 32. Raise out_rdy -> same cycle takes 32 and accepts beat 4; next cycle out=16, out_v=1.
4. Reset mid-vector: 2 beats of 8'hFF, assert rst for 1 cycle, then 4 beats of 8'h01 -> out=4 (not 20). out_v=0 and out=0 during and right after reset.
5. Gapped input: in_v toggled 1/0 across 4 beats of 8'h03 with random in_xnor on the invalid cycles -> out=8.
6. SF=1, SIMD=8: continuous beats 8'h01, 8'h03, 8'h07 with out_rdy=1 -> out=1, 2, 3 on consecutive cycles, each one cycle after its beat.
